alu_op_scheduler: RTL and testbench
===================================

Name: alu_op_scheduler

Overview:
- Shares the single floating-point/logic ALU between two requesters.
- Arbitrates requests round-robin and drives the ALU opcode and operands.
- Holds the operands stable for the ALU's fixed result latency, then captures the ALU output.
- Returns the result, tagged with the requester id, on one response channel.

Parameters:
LATENCY, 2, clock edges from the ALU-input update edge to the edge at which alu_o is valid and captured; legal range 1..15
CNT_W, 4, width of the latency counter; must hold LATENCY

Ports:
clk  input  1  system clock, all state updates on posedge
rst_n  input  1  asynchronous active-low reset
req0_valid  input  1  requester 0 has a command
req0_ready  output  1  requester 0 command accepted this cycle
req0_op  input  3  opcode: 000 ADD, 001 SUB, 010 DIV, 011 MUL, 100 AND, 101 OR, 110 NOT, 111 illegal
req0_a  input  32  operand A (IEEE-754 single for arithmetic ops)
req0_b  input  32  operand B
req1_valid  input  1  as req0
req1_ready  output  1  as req0
req1_op  input  3  as req0
req1_a  input  32  as req0
req1_b  input  32  as req0
alu_op  output  3  registered opcode to the ALU OPERATIONCODE
alu_a  output  32  registered operand A to the ALU
alu_b  output  32  registered operand B to the ALU
alu_o  input  32  ALU result O
rsp_valid  output  1  response available
rsp_ready  input  1  response consumer ready
rsp_id  output  1  requester that issued the command
rsp_data  output  32  captured result
rsp_err  output  1  illegal opcode, rsp_data=0
busy  output  1  state != IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: state IDLE, alu_op=000, alu_a=alu_b=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0, counter=0, priority pointer=req0.
- States: IDLE, WAIT, RESP.

IDLE:
- Grant is combinational from the valids and the pointer.
- One valid only: that requester wins.
- Both valid: the pointer side wins.
- reqN_ready = (state==IDLE) & grantN. At most one ready is high; no ready is high outside IDLE.
- Accept edge (valid & ready): load alu_op/alu_a/alu_b from the winner, rsp_id=winner, pointer flips to the other requester.
- Legal op on accept: go to WAIT, counter=LATENCY.
- Illegal op 111 on accept: go straight to RESP with rsp_err=1, rsp_data=0. ALU registers are still loaded, but the result is ignored.

WAIT:
- Counter decrements each edge.
- At the edge where the counter==1: rsp_data<=alu_o, rsp_err<=0, rsp_valid<=1, go to RESP.
- rsp_valid therefore rises exactly LATENCY edges after the accept edge.
- alu_op/alu_a/alu_b are held constant throughout WAIT and RESP.

RESP:
- rsp_valid, rsp_id, rsp_data and rsp_err are held stable until the rsp_ready handshake.
- On the edge with rsp_valid & rsp_ready: rsp_valid<=0, go to IDLE.
- A new accept cannot happen in the same cycle; the earliest next accept is one edge later.
- Minimum per-command occupancy is LATENCY+2 cycles for a legal op and 2 cycles for an illegal op.

Rules:
- Requester inputs are sampled only at the accept edge; later changes are ignored.
- No starvation: with both requesters continuously valid, grants strictly alternate.
- The pointer changes only on an accept.
- rsp_ready while rsp_valid=0 has no effect.
- The scheduler performs no special-value handling; NaN/inf/zero behaviour is the ALU's.
- Reset mid-operation: asynchronous return to reset values. The in-flight command is dropped with no response, and the pointer returns to req0.

Test Plan:
- Single ADD, LATENCY=2: req0 op=000, a=0x3F800000, b=0x40000000, ALU model gives 0x40400000 -> req0_ready high one cycle; rsp_valid rises 2 edges later with rsp_data=0x40400000, rsp_id=0, rsp_err=0; alu_a/alu_b stable until the response is taken.
- Contention: both valid continuously, req0 MUL 0x40000000*0x40400000, req1 AND 0xFFFF0000&0x0F0F0F0F -> grants ordered req0, req1, req0, req1; responses 0x40C00000 id0 and 0x0F0F0000 id1.
- Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid -> rsp_* stable, both readys low, busy=1; rsp_ready=1 -> IDLE on the next edge, next accept one edge later.
- Illegal op: req1 op=111 -> accepted; the next edge gives rsp_valid=1, rsp_err=1, rsp_data=0, rsp_id=1, with no WAIT state.
- Reset mid-WAIT: deassert rst_n during WAIT -> all outputs return to reset values immediately; no response after release; the first grant under contention goes to req0.
- LATENCY=1 and LATENCY=15 builds: the response edge offset from the accept edge equals LATENCY exactly.

Source files
------------

// File: rtl/alu_op_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : alu_op_scheduler
// Description : Shares one fixed-latency ALU between two requesters. Requests
//               are granted round-robin, operands are held in registers for
//               the ALU latency, and the tagged result is returned on a
//               single valid/ready response channel.
// Revision    : 1.0  initial release
// ============================================================================
module alu_op_scheduler #(
    parameter int LATENCY = 2,
    parameter int CNT_W   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [2:0]  req0_op,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [2:0]  req1_op,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic [2:0]  alu_op,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [31:0] alu_o,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic        busy
);

    localparam logic [2:0]       c_OP_ILLEGAL = 3'b111;
    localparam logic [CNT_W-1:0] c_CNT_LOAD   = CNT_W'(LATENCY);
    localparam logic [CNT_W-1:0] c_CNT_ONE    = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_nextState;
    logic             r_ptr;        // 0: req0 has priority on contention
    logic [CNT_W-1:0] r_cnt;

    logic             w_grant0;
    logic             w_grant1;
    logic             w_accept;
    logic             w_winner;
    logic [2:0]       w_selOp;
    logic [31:0]      w_selA;
    logic [31:0]      w_selB;
    logic             w_illegal;
    logic             w_capture;
    logic             w_rspDone;

    // Round-robin grant: a lone requester always wins, the pointer breaks ties.
    always_comb begin
        w_grant0 = req0_valid & (~req1_valid | ~r_ptr);
        w_grant1 = req1_valid & (~req0_valid |  r_ptr);
    end

    assign req0_ready = (r_state == IDLE) & w_grant0;
    assign req1_ready = (r_state == IDLE) & w_grant1;
    assign w_accept   = req0_ready | req1_ready;
    assign w_winner   = req1_ready;
    assign w_selOp    = w_winner ? req1_op : req0_op;
    assign w_selA     = w_winner ? req1_a  : req0_a;
    assign w_selB     = w_winner ? req1_b  : req0_b;
    assign w_illegal  = (w_selOp == c_OP_ILLEGAL);
    assign w_capture  = (r_state == WAIT) && (r_cnt == c_CNT_ONE);
    assign w_rspDone  = (r_state == RESP) && rsp_valid && rsp_ready;
    assign busy       = (r_state != IDLE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic; illegal opcodes skip the ALU wait entirely.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_nextState = w_illegal ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (w_capture) begin
                    w_nextState = RESP;
                end
            end
            RESP: begin
                if (w_rspDone) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // ALU operand registers, loaded only on accept so they stay stable until the next command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_op <= 3'b000;
            alu_a  <= 32'd0;
            alu_b  <= 32'd0;
            rsp_id <= 1'b0;
            r_ptr  <= 1'b0;
        end else if (w_accept) begin
            alu_op <= w_selOp;
            alu_a  <= w_selA;
            alu_b  <= w_selB;
            rsp_id <= w_winner;
            r_ptr  <= ~w_winner;
        end
    end

    // Latency counter: loaded on a legal accept, counts down while waiting for the ALU.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_accept && !w_illegal) begin
            r_cnt <= c_CNT_LOAD;
        end else if (r_state == WAIT) begin
            r_cnt <= r_cnt - c_CNT_ONE;
        end
    end

    // Response registers: set by capture or illegal accept, cleared by the handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_data  <= 32'd0;
            rsp_err   <= 1'b0;
        end else if (w_accept && w_illegal) begin
            rsp_valid <= 1'b1;
            rsp_data  <= 32'd0;
            rsp_err   <= 1'b1;
        end else if (w_capture) begin
            rsp_valid <= 1'b1;
            rsp_data  <= alu_o;
            rsp_err   <= 1'b0;
        end else if (w_rspDone) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_op_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_op_scheduler
// Description : Directed self-checking bench for alu_op_scheduler. Instance 0
//               uses LATENCY=2; instances 1 and 2 use LATENCY=1 and 15. Each
//               instance drives a latency-aware ALU model that only presents
//               a valid result once its inputs have been stable long enough.
// Revision    : 1.0  initial release
// ============================================================================
module tb_alu_op_scheduler;

    localparam int NI = 3;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        req0Valid [NI];
    logic        req0Ready [NI];
    logic [2:0]  req0Op    [NI];
    logic [31:0] req0A     [NI];
    logic [31:0] req0B     [NI];
    logic        req1Valid [NI];
    logic        req1Ready [NI];
    logic [2:0]  req1Op    [NI];
    logic [31:0] req1A     [NI];
    logic [31:0] req1B     [NI];
    logic [2:0]  aluOp     [NI];
    logic [31:0] aluA      [NI];
    logic [31:0] aluB      [NI];
    logic        rspValid  [NI];
    logic        rspReady  [NI];
    logic        rspId     [NI];
    logic [31:0] rspData   [NI];
    logic        rspErr    [NI];
    logic        busy      [NI];

    int checks;
    int errors;

    always #5 clk = ~clk;

    // Reference ALU with hand-computed float results for the vectors used here.
    function automatic logic [31:0] aluModel(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'b000:  return (a == 32'h3F800000 && b == 32'h40000000) ? 32'h40400000 : 32'hBADC0DE0;
            3'b001:  return (a == 32'h40400000 && b == 32'h3F800000) ? 32'h40000000 : 32'hBADC0DE1;
            3'b011:  return (a == 32'h40000000 && b == 32'h40400000) ? 32'h40C00000 : 32'hBADC0DE3;
            3'b100:  return a & b;
            3'b101:  return a | b;
            3'b110:  return ~a;
            default: return 32'hBADC0DE7;
        endcase
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 15);

        logic [66:0] curIn;
        logic [66:0] prevIn = '0;
        int          stableCnt = 0;
        int          age;
        logic [31:0] aluO;

        assign curIn = {aluOp[g], aluA[g], aluB[g]};
        always_comb age = (curIn != prevIn) ? 0 : stableCnt;
        assign aluO = (age >= LAT - 1) ? aluModel(aluOp[g], aluA[g], aluB[g]) : 32'hBADBAD00;

        always @(posedge clk) begin
            prevIn    <= curIn;
            stableCnt <= (curIn == prevIn) ? ((stableCnt < 100) ? stableCnt + 1 : stableCnt) : 1;
        end

        alu_op_scheduler #(.LATENCY(LAT), .CNT_W(4)) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .req0_valid (req0Valid[g]),
            .req0_ready (req0Ready[g]),
            .req0_op    (req0Op[g]),
            .req0_a     (req0A[g]),
            .req0_b     (req0B[g]),
            .req1_valid (req1Valid[g]),
            .req1_ready (req1Ready[g]),
            .req1_op    (req1Op[g]),
            .req1_a     (req1A[g]),
            .req1_b     (req1B[g]),
            .alu_op     (aluOp[g]),
            .alu_a      (aluA[g]),
            .alu_b      (aluB[g]),
            .alu_o      (aluO),
            .rsp_valid  (rspValid[g]),
            .rsp_ready  (rspReady[g]),
            .rsp_id     (rspId[g]),
            .rsp_data   (rspData[g]),
            .rsp_err    (rspErr[g]),
            .busy       (busy[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One ADD on instance i, measuring accept-to-response edges.
    task automatic runLatency(input int i, input int lat);
        int n;
        rspReady[i]  = 1'b1;
        req0Op[i]    = 3'b000;
        req0A[i]     = 32'h3F800000;
        req0B[i]     = 32'h40000000;
        req0Valid[i] = 1'b1;
        #1;
        chk($sformatf("lat%0d_rdy0", lat), req0Ready[i], 1'b1);
        tick();
        req0Valid[i] = 1'b0;
        n = 0;
        while (!rspValid[i] && n < 40) begin
            tick();
            n++;
        end
        chk($sformatf("lat%0d_edges", lat), n, lat);
        chk($sformatf("lat%0d_data", lat), rspData[i], 32'h40400000);
        tick();
        chk($sformatf("lat%0d_idle", lat), busy[i], 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        for (int i = 0; i < NI; i++) begin
            req0Valid[i] = 1'b0; req0Op[i] = 3'b000; req0A[i] = 32'd0; req0B[i] = 32'd0;
            req1Valid[i] = 1'b0; req1Op[i] = 3'b000; req1A[i] = 32'd0; req1B[i] = 32'd0;
            rspReady[i]  = 1'b0;
        end

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_aluop",   aluOp[0],    3'b000);
        chk("rst_alua",    aluA[0],     32'd0);
        chk("rst_alub",    aluB[0],     32'd0);
        chk("rst_rspv",    rspValid[0], 1'b0);
        chk("rst_rspid",   rspId[0],    1'b0);
        chk("rst_rspdata", rspData[0],  32'd0);
        chk("rst_rsperr",  rspErr[0],   1'b0);
        chk("rst_busy",    busy[0],     1'b0);
        rst_n = 1'b1;
        tick();

        // Contention: req0 MUL vs req1 AND, both held valid
        rspReady[0]  = 1'b1;
        req0Op[0] = 3'b011; req0A[0] = 32'h40000000; req0B[0] = 32'h40400000;
        req1Op[0] = 3'b100; req1A[0] = 32'hFFFF0000; req1B[0] = 32'h0F0F0F0F;
        req0Valid[0] = 1'b1;
        req1Valid[0] = 1'b1;
        #1;
        chk("ct1_rdy0", req0Ready[0], 1'b1);
        chk("ct1_rdy1", req1Ready[0], 1'b0);
        tick();
        chk("ct1_aluop", aluOp[0], 3'b011);
        chk("ct1_busy",  busy[0],  1'b1);
        chk("ct1_norrdy", {req0Ready[0], req1Ready[0]}, 2'b00);
        tick();
        chk("ct1_early", rspValid[0], 1'b0);
        tick();
        chk("ct1_rspv",  rspValid[0], 1'b1);
        chk("ct1_data",  rspData[0],  32'h40C00000);
        chk("ct1_id",    rspId[0],    1'b0);
        chk("ct1_err",   rspErr[0],   1'b0);
        tick();
        chk("ct2_rdy1", req1Ready[0], 1'b1);
        chk("ct2_rdy0", req0Ready[0], 1'b0);
        chk("ct2_rspv", rspValid[0],  1'b0);
        tick();
        chk("ct2_aluop", aluOp[0], 3'b100);
        chk("ct2_alua",  aluA[0],  32'hFFFF0000);

        // Backpressure on the req1 response
        rspReady[0] = 1'b0;
        repeat (2) tick();
        chk("ct2_data", rspData[0], 32'h0F0F0000);
        chk("ct2_id",   rspId[0],   1'b1);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_rspv",  rspValid[0], 1'b1);
            chk("bp_data",  rspData[0],  32'h0F0F0000);
            chk("bp_rdys",  {req0Ready[0], req1Ready[0]}, 2'b00);
            chk("bp_busy",  busy[0],     1'b1);
        end
        rspReady[0] = 1'b1;
        tick();
        chk("bp_idle",  busy[0],      1'b0);
        chk("ct3_rdy0", req0Ready[0], 1'b1);
        tick();
        chk("ct3_aluop", aluOp[0], 3'b011);
        chk("ct3_id",    rspId[0], 1'b0);
        repeat (3) tick();
        chk("ct4_rdy1", req1Ready[0], 1'b1);
        tick();
        chk("ct4_aluop", aluOp[0], 3'b100);
        req0Valid[0] = 1'b0;
        req1Valid[0] = 1'b0;
        repeat (2) tick();
        chk("ct4_id", rspId[0], 1'b1);
        tick();
        chk("ct4_idle", busy[0], 1'b0);

        // Single ADD; inputs change after accept and must be ignored
        rspReady[0] = 1'b0;
        req0Op[0] = 3'b000; req0A[0] = 32'h3F800000; req0B[0] = 32'h40000000;
        req0Valid[0] = 1'b1;
        #1;
        chk("sa_rdy0", req0Ready[0], 1'b1);
        chk("sa_rdy1", req1Ready[0], 1'b0);
        tick();
        req0Valid[0] = 1'b0;
        req0Op[0]    = 3'b011;
        req0A[0]     = 32'h12345678;
        chk("sa_alua", aluA[0], 32'h3F800000);
        chk("sa_alub", aluB[0], 32'h40000000);
        tick();
        chk("sa_early", rspValid[0], 1'b0);
        chk("sa_hold_op", aluOp[0], 3'b000);
        tick();
        chk("sa_rspv", rspValid[0], 1'b1);
        chk("sa_data", rspData[0],  32'h40400000);
        chk("sa_id",   rspId[0],    1'b0);
        chk("sa_hold_a", aluA[0],   32'h3F800000);
        rspReady[0] = 1'b1;
        tick();
        chk("sa_done", {rspValid[0], busy[0]}, 2'b00);
        rspReady[0] = 1'b0;

        // Illegal opcode from req1
        req1Op[0] = 3'b111; req1A[0] = 32'h0000AAAA; req1B[0] = 32'h00000001;
        req1Valid[0] = 1'b1;
        #1;
        chk("il_rdy1", req1Ready[0], 1'b1);
        tick();
        req1Valid[0] = 1'b0;
        chk("il_rspv",  rspValid[0], 1'b1);
        chk("il_err",   rspErr[0],   1'b1);
        chk("il_data",  rspData[0],  32'd0);
        chk("il_id",    rspId[0],    1'b1);
        chk("il_aluop", aluOp[0],    3'b111);
        rspReady[0] = 1'b1;
        tick();
        chk("il_idle", busy[0], 1'b0);
        rspReady[0] = 1'b0;

        // Reset during WAIT: req0 wins (pointer at req0), then reset restores pointer
        req0Op[0] = 3'b001; req0A[0] = 32'h40400000; req0B[0] = 32'h3F800000;
        req1Op[0] = 3'b101; req1A[0] = 32'h00FF0000; req1B[0] = 32'h000000FF;
        req0Valid[0] = 1'b1;
        req1Valid[0] = 1'b1;
        tick();
        req0Valid[0] = 1'b0;
        req1Valid[0] = 1'b0;
        chk("rs_busy", busy[0], 1'b1);
        chk("rs_alua", aluA[0], 32'h40400000);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rs_alua0",  aluA[0],  32'd0);
        chk("rs_aluop0", aluOp[0], 3'b000);
        chk("rs_busy0",  busy[0],  1'b0);
        tick();
        rst_n = 1'b1;
        rspReady[0] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("rs_norsp", rspValid[0], 1'b0);
        end
        req0Valid[0] = 1'b1;
        req1Valid[0] = 1'b1;
        #1;
        chk("rs_ptr0", req0Ready[0], 1'b1);
        chk("rs_ptr1", req1Ready[0], 1'b0);
        tick();
        req0Valid[0] = 1'b0;
        req1Valid[0] = 1'b0;
        repeat (2) tick();
        chk("rs_data", rspData[0], 32'h40000000);
        tick();
        chk("rs_idle", busy[0], 1'b0);

        // Latency builds
        runLatency(1, 1);
        runLatency(2, 15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
